// File: rtl/imem_port_arbiter.sv
// rtl/imem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
// Data has priority; a burst counter forces a fetch after MAX_DATA_BURST data grants.
module imem_port_arbiter #(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        FREEZE,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] burst_cnt;
  logic       if_elig;
  logic       d_elig;
  logic       arb_en;
  logic       grant_if;
  logic       grant_d;
  logic       ack_if;
  logic       ack_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nx = BUSY_D;
        end else if (grant_if) begin
          state_nx = BUSY_IF;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          state_nx = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_ack) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Completion cycles are an arbitration bubble, so back-to-back data traffic
  // still sees the fetch competing and the burst guard can engage.
  always_comb begin
    if_elig  = if_req & ~if_valid;
    d_elig   = d_req & ~d_valid;
    arb_en   = (state == IDLE) & ~if_valid & ~d_valid;
    grant_d  = arb_en & d_elig & (~if_elig | (burst_cnt != BURST_MAX));
    grant_if = arb_en & if_elig & ~grant_d;
    ack_if   = (state == BUSY_IF) & mem_ack;
    ack_d    = (state == BUSY_D) & mem_ack;
    FREEZE   = if_req & ~if_valid;
    d_stall  = d_req & ~d_valid;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      burst_cnt <= 4'd0;
    end else if (grant_if) begin
      burst_cnt <= 4'd0;
    end else if (grant_d) begin
      if (!if_elig) begin
        burst_cnt <= 4'd0;
      end else if (burst_cnt != BURST_MAX) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
    end else if (grant_d) begin
      mem_req   <= 1'b1;
      mem_we    <= d_we;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      mem_be    <= d_be;
    end else if (grant_if) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
      mem_wdata <= 32'd0;
      mem_be    <= 4'hF;
    end else if (ack_if || ack_d) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  // mem_we still reflects the data transaction on its ack edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if_rdata <= 32'd0;
      d_rdata  <= 32'd0;
    end else begin
      if_valid <= ack_if;
      d_valid  <= ack_d;
      if (ack_if) begin
        if_rdata <= mem_rdata;
      end
      if (ack_d && !mem_we) begin
        d_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb/tb_imem_port_arbiter.sv - directed vector bench for imem_port_arbiter
module tb_imem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        FREEZE;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  imem_port_arbiter #(.MAX_DATA_BURST(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .FREEZE(FREEZE),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic got;

    vecs[0] = '{1'b0, 1'b0, 32'h00400004, 32'h0, 4'h0, 0, 32'h24080001, 1'b0, 4'hF, 32'h0, 32'h24080001};
    vecs[1] = '{1'b1, 1'b0, 32'h10010000, 32'h0, 4'hF, 0, 32'h00000055, 1'b0, 4'hF, 32'h0, 32'h00000055};
    vecs[2] = '{1'b1, 1'b1, 32'h10010004, 32'hDEADBEEF, 4'b0011, 1, 32'h12345678, 1'b1, 4'b0011, 32'hDEADBEEF, 32'h00000055};
    vecs[3] = '{1'b1, 1'b0, 32'h10010008, 32'h0, 4'b1100, 2, 32'hA5A5A5A5, 1'b0, 4'b1100, 32'h0, 32'hA5A5A5A5};
    vecs[4] = '{1'b0, 1'b0, 32'h00400008, 32'h0, 4'h0, 3, 32'h1000FFFF, 1'b0, 4'hF, 32'h0, 32'h1000FFFF};

    RESET = 1'b0;
    if_req = 1'b1;
    if_addr = 32'h00400000;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = 32'h0;
    d_wdata = 32'h0;
    d_be = 4'h0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;

    // reset with a pending fetch
    tick();
    tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_valids", 32'({if_valid, d_valid}), 32'd0);
    check("rst_freeze", 32'(FREEZE), 32'd1);
    check("rst_d_stall", 32'(d_stall), 32'd0);
    RESET = 1'b1;
    tick();
    check("post_rst_mem_req", 32'(mem_req), 32'd1);
    check("post_rst_mem_addr", mem_addr, 32'h00400000);
    check("post_rst_mem_be", 32'(mem_be), 32'hF);

    // fetch with one memory wait cycle
    tick();
    check("fetch_wait_freeze", 32'(FREEZE), 32'd1);
    check("fetch_wait_valid", 32'(if_valid), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h8C220004;
    tick();
    mem_ack = 1'b0;
    check("fetch_valid", 32'(if_valid), 32'd1);
    check("fetch_rdata", if_rdata, 32'h8C220004);
    check("fetch_freeze_low", 32'(FREEZE), 32'd0);
    check("fetch_mem_req_drop", 32'(mem_req), 32'd0);
    if_req = 1'b0;
    tick();
    check("fetch_valid_once", 32'(if_valid), 32'd0);
    check("fetch_rdata_hold", if_rdata, 32'h8C220004);
    check("fetch_no_regrant", 32'(mem_req), 32'd0);

    // single-requester vectors
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      if (v.is_d) begin
        d_req = 1'b1;
        d_we = v.we;
        d_addr = v.addr;
        d_wdata = v.wdata;
        d_be = v.be;
      end else begin
        if_req = 1'b1;
        if_addr = v.addr;
      end
      tick();
      check($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'd1);
      check($sformatf("v%0d_mem_addr", i), mem_addr, v.addr);
      check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(v.exp_we));
      check($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(v.exp_be));
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, v.exp_wdata);
      for (int w = 0; w < v.waits; w++) begin
        tick();
        check($sformatf("v%0d_hold_req", i), 32'(mem_req), 32'd1);
        check($sformatf("v%0d_hold_we", i), 32'(mem_we), 32'(v.exp_we));
        check($sformatf("v%0d_stall", i), 32'(v.is_d ? d_stall : FREEZE), 32'd1);
      end
      mem_ack = 1'b1;
      mem_rdata = v.rdata;
      tick();
      mem_ack = 1'b0;
      check($sformatf("v%0d_valid", i), 32'(v.is_d ? d_valid : if_valid), 32'd1);
      check($sformatf("v%0d_other_valid", i), 32'(v.is_d ? if_valid : d_valid), 32'd0);
      check($sformatf("v%0d_rdata", i), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
      check($sformatf("v%0d_stall_low", i), 32'(v.is_d ? d_stall : FREEZE), 32'd0);
      check($sformatf("v%0d_mem_we_drop", i), 32'({mem_req, mem_we}), 32'd0);
      if_req = 1'b0;
      d_req = 1'b0;
      tick();
      check($sformatf("v%0d_valid_drop", i), 32'({if_valid, d_valid}), 32'd0);
    end

    // simultaneous requests: data first, then fetch after the bubble
    if_req = 1'b1;
    if_addr = 32'h0040000C;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h10010000;
    d_be = 4'hF;
    tick();
    check("both_grant_addr", mem_addr, 32'h10010000);
    check("both_freeze", 32'(FREEZE), 32'd1);
    mem_ack = 1'b1;
    mem_rdata = 32'h00000077;
    tick();
    mem_ack = 1'b0;
    check("both_d_valid", 32'(d_valid), 32'd1);
    check("both_d_rdata", d_rdata, 32'h00000077);
    check("both_freeze_in_dvalid", 32'(FREEZE), 32'd1);
    d_req = 1'b0;
    tick();
    check("both_bubble", 32'(mem_req), 32'd0);
    tick();
    check("both_fetch_req", 32'(mem_req), 32'd1);
    check("both_fetch_addr", mem_addr, 32'h0040000C);
    mem_ack = 1'b1;
    mem_rdata = 32'h03E00008;
    tick();
    mem_ack = 1'b0;
    check("both_if_valid", 32'(if_valid), 32'd1);
    check("both_if_rdata", if_rdata, 32'h03E00008);
    if_req = 1'b0;
    tick();

    // continuous traffic: starvation guard
    if_addr = 32'h00400100;
    d_addr = 32'h10010020;
    d_we = 1'b0;
    if_req = 1'b1;
    d_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        tick();
        if (mem_req) got = 1'b1;
      end
      check($sformatf("burst%0d_granted", i), 32'(got), 32'd1);
      check($sformatf("burst%0d_is_data", i), 32'(mem_addr == 32'h10010020), 32'((i % 5) != 4));
      mem_ack = 1'b1;
      mem_rdata = 32'(i);
      tick();
      mem_ack = 1'b0;
      check($sformatf("burst%0d_valids", i), 32'({if_valid, d_valid}), ((i % 5) != 4) ? 32'd1 : 32'd2);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    tick();
    tick();

    // reset while a data read is in flight, late ack after release
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h10010010;
    tick();
    check("rstd_busy", 32'(mem_req), 32'd1);
    RESET = 1'b0;
    #1;
    check("rstd_async_drop", 32'(mem_req), 32'd0);
    check("rstd_d_rdata_clr", d_rdata, 32'h0);
    tick();
    RESET = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'h00000099;
    tick();
    mem_ack = 1'b0;
    check("rstd_no_valid", 32'(d_valid), 32'd0);
    check("rstd_no_load", d_rdata, 32'h0);
    check("rstd_regrant", 32'(mem_req), 32'd1);
    check("rstd_regrant_addr", mem_addr, 32'h10010010);
    tick();
    check("rstd_still_no_valid", 32'(d_valid), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'h00001234;
    tick();
    mem_ack = 1'b0;
    check("rstd_valid", 32'(d_valid), 32'd1);
    check("rstd_rdata", d_rdata, 32'h00001234);
    d_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Arbitrates a single-ported unified instruction/data memory between the IF stage fetch path and the MEM-stage load/store path. Drives the IF stage's `FREEZE` input while a fetch is outstanding or losing arbitration, and drives a matching stall to the data side. Sequences each memory transaction through a req/ack handshake. A starvation guard guarantees fetch progress under continuous data traffic.

## Interface
Parameters:
- `MAX_DATA_BURST`, default 4: maximum consecutive data grants while a fetch is pending before fetch is forced; legal range 1..15.

Ports:
- `CLK` input 1: clock, rising edge.
- `RESET` input 1: reset, asynchronous, active-low.
- `if_req` input 1: fetch request; held with `if_addr` stable until `if_valid`.
- `if_addr` input 32: fetch address.
- `if_rdata` output 32: fetched instruction; valid when `if_valid`.
- `if_valid` output 1: one-cycle fetch completion pulse.
- `FREEZE` output 1: to IF; equals `if_req & ~if_valid`.
- `d_req` input 1: data request; held with address/controls stable until `d_valid`.
- `d_we` input 1: 1 = write, 0 = read.
- `d_addr` input 32: data address.
- `d_wdata` input 32: write data.
- `d_be` input 4: byte enables, bit i enables byte lane i.
- `d_rdata` output 32: read data; valid when `d_valid` on a read.
- `d_valid` output 1: one-cycle data completion pulse.
- `d_stall` output 1: equals `d_req & ~d_valid`.
- `mem_req` output 1: memory request, held until `mem_ack`.
- `mem_we` output 1: memory write strobe.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_be` output 4: memory byte enables.
- `mem_ack` input 1: one-cycle completion from memory; `mem_rdata` valid the same cycle.
- `mem_rdata` input 32: memory read data.

## Operation
- States: `IDLE`, `BUSY_IF`, `BUSY_D`.
- Eligible requests in IDLE: `if_req & ~if_valid` and `d_req & ~d_valid`. A requester's req is ignored during its own valid cycle, so no stale regrant occurs.
- Arbitration in IDLE:
  - Only one requester eligible: that requester wins.
  - Both eligible: data wins unless `burst_cnt == MAX_DATA_BURST`, in which case fetch wins.
- `burst_cnt`:
  - Increments on a data grant made while fetch is eligible.
  - Clears on any fetch grant, and on a data grant made with fetch not eligible.
  - Saturates at `MAX_DATA_BURST`.
- On a grant, at the clock edge: latch the `mem_*` registers (fetch: `mem_we=0`, `mem_be=4'hF`, `mem_wdata=0`), assert `mem_req`, and move to `BUSY_x`.
- `BUSY_x` with `mem_ack`, at the clock edge:
  - Deassert `mem_req` and `mem_we`.
  - Pulse `x_valid`.
  - For fetch, or a data read, load `x_rdata <= mem_rdata`. On a data write, `d_rdata` is unchanged.
  - Return to IDLE.
- `mem_ack` in IDLE is ignored.
- A requester dropping req mid-transaction does not abort it: the transaction completes and valid still pulses.
- `if_rdata` and `d_rdata` hold their last value until overwritten.

## Timing
- Reset values: `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_be=0`, `if_rdata=0`, `d_rdata=0`, `if_valid=0`, `d_valid=0`. State is IDLE and `burst_cnt=0`. `FREEZE` and `d_stall` follow their equations.
- Reset mid-transaction: `mem_req` drops asynchronously and the state returns to IDLE. A late `mem_ack` arriving after reset release is ignored.
- Request seen in IDLE at edge N: `mem_req` is high from N+1.
- `mem_ack` sampled at edge M: valid is high for cycle M+1, and the state is IDLE in that same cycle.
- Minimum transaction with zero-wait memory (ack in the first `mem_req` cycle): 2 cycles from req to valid, plus a 1-cycle IDLE bubble between transactions.
- `FREEZE` and `d_stall` are combinational from inputs and registered valids. They are low exactly in the valid cycle, so the requester advances on that edge.

## Test plan
- Reset with `if_req=1`, `if_addr=0x00400000`: all registered outputs 0 and `FREEZE=1` during reset. After release, `mem_req=1` and `mem_addr=0x00400000` one cycle later.
- Fetch only, ack 1 cycle after `mem_req`, `mem_rdata=0x8C220004` → `if_valid` pulses once, `if_rdata=0x8C220004`, `FREEZE=0` during the pulse cycle only.
- Simultaneous `if_req` and `d_req` read at `0x10010000` → data granted first; fetch granted next with `FREEZE=1` throughout the data transaction.
- Continuous `d_req` plus `if_req`, `MAX_DATA_BURST=4` → grant order D,D,D,D,IF,D,D,D,D,IF…
- Data write, `d_be=4'b0011`, `d_wdata=0xDEADBEEF` → `mem_we=1`, `mem_be=4'b0011` while `mem_req` is high; on `d_valid`, `d_rdata` is unchanged.
- `RESET` pulsed low while in `BUSY_D`, then `mem_ack` asserted 1 cycle after release → `mem_req=0` immediately, no `d_valid` pulse, and a fresh arbitration round follows.
